// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU and the iterative mul/div unit.
//   - ALU_* : 4-bit op codes of the shared ALU encoding (0..13)
//   - md_state_e : control states of muldiv_unit
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_MUL  = 4'd8;
  localparam logic [3:0] ALU_MULH = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;
  localparam logic [3:0] ALU_REM  = 4'd11;
  localparam logic [3:0] ALU_SLT  = 4'd12;
  localparam logic [3:0] ALU_SLTU = 4'd13;

  // IDLE waits for a request, CALC decodes and iterates, FIX applies the
  // sign and selects the result word, DONE presents it until consumed.
  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// muldiv_unit_if
// Request/response channel between the execute stage and muldiv_unit.
//   in_valid/in_ready  : request handshake, carries in_a, in_b, in_op
//   flush              : synchronous abort of the in-flight operation
//   out_valid/out_ready: response handshake, carries out_result
// Modports: master = pipeline side, slave = muldiv_unit.
// ----------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int XLEN = 64,
  parameter int OP_W = 4
) ();

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [OP_W-1:0] in_op;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_a, in_b, in_op, flush, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, flush, out_ready,
    output in_ready, out_valid, out_result
  );

endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Iterative radix-2 unit for mul, mulh, div and rem (signed, RV64M rules).
// One request in flight; the pipeline stalls on in_ready/out_valid.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_unit_if slave (request, flush, response channels)
// ----------------------------------------------------------------------------
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OP_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam int              CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] sreg_q, sreg_d;
  logic [XLEN-1:0] breg_q, breg_d;
  logic            neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_mul, is_div;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN+1:0] add_a, add_b, add_sum;
  logic            add_cin;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign is_mul = (op_q == ALU_MUL) || (op_q == ALU_MULH);
  assign is_div = (op_q == ALU_DIV) || (op_q == ALU_REM);

  // Raw operands sit in sreg/breg during the first CALC cycle, so their
  // signs and magnitudes are derived from there.
  assign a_neg = sreg_q[XLEN-1];
  assign b_neg = breg_q[XLEN-1];
  assign a_mag = a_neg ? (~sreg_q + 1'b1) : sreg_q;
  assign b_mag = b_neg ? (~breg_q + 1'b1) : breg_q;

  // Single adder shared by both algorithms: mul adds the multiplicand when
  // the current multiplier bit is set; div subtracts the divisor from the
  // remainder shifted left by one, and the top bit flags a failed trial.
  always_comb begin
    if (is_mul) begin
      add_a   = {2'b00, acc_q};
      add_b   = sreg_q[0] ? {2'b00, breg_q} : '0;
      add_cin = 1'b0;
    end else begin
      add_a   = {1'b0, acc_q, sreg_q[XLEN-1]};
      add_b   = ~{2'b00, breg_q};
      add_cin = 1'b1;
    end
    add_sum = add_a + add_b + {{(XLEN+1){1'b0}}, add_cin};
  end

  // Sign correction applied in FIX on the unsigned product or quotient and
  // remainder.
  assign prod_fix = neg_q ? (~{acc_q, sreg_q} + 1'b1) : {acc_q, sreg_q};
  assign quo_fix  = neg_q ? (~sreg_q + 1'b1) : sreg_q;
  assign rem_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;

  // Next-state logic. cnt_q == 0 in CALC marks the decode cycle, which either
  // resolves a fast-path case or loads magnitudes and starts the XLEN
  // iterations; the count returns to 0 on the last iteration.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    sreg_d   = sreg_q;
    breg_d   = breg_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      MD_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          op_d    = bus.in_op;
          sreg_d  = bus.in_a;
          breg_d  = bus.in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MD_CALC;
        end
      end
      MD_CALC: begin
        if (cnt_q == '0) begin
          if (!is_mul && !is_div) begin
            result_d = '0;
            state_d  = MD_DONE;
          end else if (is_div && breg_q == '0) begin
            result_d = (op_q == ALU_DIV) ? '1 : sreg_q;
            state_d  = MD_DONE;
          end else if (is_div && sreg_q == MIN_NEG && breg_q == '1) begin
            result_d = (op_q == ALU_DIV) ? sreg_q : '0;
            state_d  = MD_DONE;
          end else begin
            sreg_d = a_mag;
            breg_d = b_mag;
            acc_d  = '0;
            neg_d  = (op_q == ALU_REM) ? a_neg : (a_neg ^ b_neg);
            cnt_d  = CNT_LOAD;
          end
        end else begin
          if (is_mul) begin
            acc_d  = add_sum[XLEN:1];
            sreg_d = {add_sum[0], sreg_q[XLEN-1:1]};
          end else if (add_sum[XLEN+1]) begin
            acc_d  = {acc_q[XLEN-2:0], sreg_q[XLEN-1]};
            sreg_d = {sreg_q[XLEN-2:0], 1'b0};
          end else begin
            acc_d  = add_sum[XLEN-1:0];
            sreg_d = {sreg_q[XLEN-2:0], 1'b1};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = MD_FIX;
          end
        end
      end
      MD_FIX: begin
        unique case (op_q)
          ALU_MUL:  result_d = prod_fix[XLEN-1:0];
          ALU_MULH: result_d = prod_fix[2*XLEN-1:XLEN];
          ALU_DIV:  result_d = quo_fix;
          default:  result_d = rem_fix;
        endcase
        state_d = MD_DONE;
      end
      MD_DONE: begin
        if (bus.out_ready) begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase

    if (bus.flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      sreg_q   <= '0;
      breg_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      sreg_q   <= sreg_d;
      breg_q   <= breg_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready   = (state_q == MD_IDLE);
  assign bus.out_valid  = (state_q == MD_DONE);
  assign bus.out_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: directed cases, randomized operations
// against a signed-arithmetic reference model, backpressure, flush and
// asynchronous reset.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
  import alu_pkg::*;

  localparam logic [63:0] MIN_NEG  = 64'h8000_0000_0000_0000;
  localparam int          CALC_LAT = 66;

  logic clk = 1'b0;
  logic rst_n;
  int   checkCount = 0;
  int   passCount  = 0;

  muldiv_unit_if #(.XLEN(64), .OP_W(4)) bus ();

  muldiv_unit #(.XLEN(64), .OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
  endtask

  // Reference result from the signed RV64M rules using wide arithmetic.
  function automatic logic [63:0] refResult(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] op);
    logic signed [127:0] prod;
    longint              sa, sb;
    logic [63:0]         res;
    sa   = a;
    sb   = b;
    prod = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    case (op)
      ALU_MUL:  res = prod[63:0];
      ALU_MULH: res = prod[127:64];
      ALU_DIV: begin
        if (b == 64'd0)                       res = '1;
        else if (a == MIN_NEG && b == '1)     res = a;
        else                                  res = 64'(sa / sb);
      end
      ALU_REM: begin
        if (b == 64'd0)                       res = a;
        else if (a == MIN_NEG && b == '1)     res = 64'd0;
        else                                  res = 64'(sa % sb);
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Cycles from acceptance edge to out_valid: short for trivially resolved
  // requests, full iteration otherwise.
  function automatic int refLatency(input logic [63:0] a, input logic [63:0] b,
                                    input logic [3:0] op);
    if (op != ALU_MUL && op != ALU_MULH && op != ALU_DIV && op != ALU_REM) return 1;
    if ((op == ALU_DIV || op == ALU_REM) && (b == 64'd0 || (a == MIN_NEG && b == '1))) return 1;
    return CALC_LAT;
  endfunction

  function automatic logic [63:0] randOperand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'd0;
      1:       v = '1;
      2:       v = MIN_NEG;
      3:       v = 64'($urandom_range(0, 100));
      4:       v = -64'($urandom_range(1, 100));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Issues one request, measures latency, checks the result, optionally holds
  // off the consumer for a number of cycles, then completes the handshake.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic [3:0] op, input int hold, input string tag);
    logic [63:0] expRes;
    int          expLat;
    int          lat;
    expRes = refResult(a, b, op);
    expLat = refLatency(a, b, op);
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_op     = op;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_result"}, bus.out_result, expRes);
    checkOutput({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_result"}, bus.out_result, expRes);
      checkOutput({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      checkOutput({tag, "_hold_busy"}, 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_released"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, "_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic        seen;
    logic [63:0] ra, rb;
    logic [3:0]  rop;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    #2;
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_out_result", bus.out_result, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed multiply cases");
    applyStimulus(64'd6, 64'd5, ALU_MUL, 0, "mul_6x5");
    applyStimulus(-64'd3, 64'd7, ALU_MUL, 0, "mul_neg3x7");
    applyStimulus(MIN_NEG, 64'd4, ALU_MULH, 0, "mulh_min_x4");
    applyStimulus(64'h1_0000_0000, 64'h1_0000_0000, ALU_MULH, 0, "mulh_2p32sq");

    $display("[TB] directed divide cases");
    applyStimulus(64'd66, 64'd11, ALU_DIV, 0, "div_66_11");
    applyStimulus(64'd62, 64'd3, ALU_REM, 0, "rem_62_3");
    applyStimulus(-64'd7, 64'd2, ALU_DIV, 0, "div_neg7_2");
    applyStimulus(-64'd7, 64'd2, ALU_REM, 0, "rem_neg7_2");
    applyStimulus(64'd7, -64'd2, ALU_DIV, 0, "div_7_neg2");
    applyStimulus(64'd7, -64'd2, ALU_REM, 0, "rem_7_neg2");

    $display("[TB] fast-path cases");
    applyStimulus(64'd42, 64'd0, ALU_DIV, 0, "div_by_zero");
    applyStimulus(64'd42, 64'd0, ALU_REM, 0, "rem_by_zero");
    applyStimulus(MIN_NEG, '1, ALU_DIV, 0, "div_overflow");
    applyStimulus(MIN_NEG, '1, ALU_REM, 0, "rem_overflow");
    applyStimulus(64'd9, 64'd3, ALU_ADD, 0, "non_muldiv_op");

    $display("[TB] backpressure");
    applyStimulus(-64'd123456789, 64'd1000, ALU_DIV, 10, "backpressure");

    $display("[TB] flush mid-calculation");
    @(negedge clk);
    bus.in_a     = 64'd6;
    bus.in_b     = 64'd5;
    bus.in_op    = ALU_MUL;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkOutput("flush_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checkOutput("flush_no_result", 64'(seen), 64'd0);

    // A request coincident with flush must not be taken.
    @(negedge clk);
    bus.in_a     = 64'd66;
    bus.in_b     = 64'd11;
    bus.in_op    = ALU_DIV;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    checkOutput("flush_suppress_accept", 64'(bus.in_ready), 64'd1);
    applyStimulus(64'd6, 64'd5, ALU_MUL, 0, "after_flush");

    $display("[TB] asynchronous reset mid-calculation");
    @(negedge clk);
    bus.in_a     = 64'd66;
    bus.in_b     = 64'd11;
    bus.in_op    = ALU_DIV;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("areset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("areset_out_result", bus.out_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(64'd66, 64'd11, ALU_DIV, 0, "after_reset");

    $display("[TB] randomized operations");
    for (int n = 0; n < 40; n++) begin
      ra  = randOperand();
      rb  = randOperand();
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                         : 4'($urandom_range(8, 11));
      applyStimulus(ra, rb, rop, $urandom_range(0, 2), $sformatf("rand%0d_op%0d", n, rop));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
